// File: rtl/sub_flags_pkg.sv
// sub_flags_pkg: shared state encoding, page field offsets and reset constants for the sub-CPU flag block
package sub_flags_pkg;
   typedef enum logic [1:0] {RUN, REQ, HALTED} halt_st_t;
   localparam int CPU_PAGE_LSB = 0;
   localparam int DISP_PAGE_LSB = 4;
   localparam logic VD_OFF_N_RST = 1'b1;
   localparam logic INS_RST = 1'b1;
endpackage

// File: rtl/sub_halt_fsm.sv
// sub_halt_fsm: main-to-sub halt handshake with sticky acknowledge timeout
// Ports: CLK, RESETn (sync, active low); halt_req/sub_halted levels in;
// halt_n/halt_ack_n/halt_to registered out; halted_entry pulses on the REQ->HALTED edge.
module sub_halt_fsm
   import sub_flags_pkg::*;
#(
   parameter int ACK_TIMEOUT = 1024,
   parameter int TO_W = 11
) (
   input  logic CLK,
   input  logic RESETn,
   input  logic halt_req,
   input  logic sub_halted,
   output logic halt_n,
   output logic halt_ack_n,
   output logic halt_to,
   output logic halted_entry
);
   localparam logic [TO_W-1:0] TO_LIM = TO_W'(ACK_TIMEOUT);
   halt_st_t state;
   logic [TO_W-1:0] cnt;
   logic [TO_W-1:0] cnt_inc;
   logic cnt_sat;
   assign cnt_inc = cnt + 1'b1;
   // with the timeout disabled the counter still runs but parks at all-ones
   assign cnt_sat = (ACK_TIMEOUT != 0) ? (cnt == TO_LIM) : (&cnt);
   // release takes priority over acknowledge, so entry needs halt_req still high
   assign halted_entry = (state == REQ) && halt_req && sub_halted;
   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         state <= RUN;
         halt_n <= 1'b1;
         halt_ack_n <= 1'b1;
         halt_to <= 1'b0;
         cnt <= '0;
      end else begin
         case (state)
            RUN: if (halt_req) begin
               state <= REQ;
               halt_n <= 1'b0;
               halt_to <= 1'b0;
               cnt <= '0;
            end
            REQ: if (!halt_req) begin
               state <= RUN;
               halt_n <= 1'b1;
            end else if (sub_halted) begin
               state <= HALTED;
               halt_ack_n <= 1'b0;
            end else if (!cnt_sat) begin
               cnt <= cnt_inc;
               if (ACK_TIMEOUT != 0 && cnt_inc == TO_LIM) halt_to <= 1'b1;
            end
            HALTED: if (!halt_req) begin
               state <= RUN;
               halt_n <= 1'b1;
               halt_ack_n <= 1'b1;
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: rtl/sub_flags_ctl.sv
// sub_flags_ctl: sub-CPU halt handshake, BUSY, IRQ latches, CRT/LED flags and VRAM page register
// Ports: CLK, RESETn (sync, active low); bus-decoder strobes busy_set/busy_clr/irq_set/irq_clr/
// crt_wr/led_wr/page_wr with data wbit/page_wdata; outputs halt_n, halt_ack_n, halt_to, busy,
// irq_pend, sub_irq_n, vpage_n, dpage, vd_off_n, ins.
// Macro SUB_IRQ_MASK_EN adds irq_mask_wr and a per-source IRQ mask loaded from page_wdata.
module sub_flags_ctl
   import sub_flags_pkg::*;
#(
   parameter int N_IRQ = 2,
   parameter int N_PAGES = 3,
   parameter int ACK_TIMEOUT = 1024,
   parameter int TO_W = 11
) (
   input  logic CLK,
   input  logic RESETn,
   input  logic halt_req,
   input  logic sub_halted,
   input  logic busy_set,
   input  logic busy_clr,
   input  logic [N_IRQ-1:0] irq_set,
   input  logic irq_clr,
`ifdef SUB_IRQ_MASK_EN
   input  logic irq_mask_wr,
`endif
   input  logic crt_wr,
   input  logic led_wr,
   input  logic wbit,
   input  logic page_wr,
   input  logic [7:0] page_wdata,
   output logic halt_n,
   output logic halt_ack_n,
   output logic busy,
   output logic sub_irq_n,
   output logic [N_IRQ-1:0] irq_pend,
   output logic [N_PAGES-1:0] vpage_n,
   output logic [N_PAGES-1:0] dpage,
   output logic vd_off_n,
   output logic ins,
   output logic halt_to
);
   logic halted_entry;
   logic [N_IRQ-1:0] mask;
   logic unused_wdata;
   assign unused_wdata = ^page_wdata;
   sub_halt_fsm #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(TO_W)) u_fsm (
      .CLK(CLK),
      .RESETn(RESETn),
      .halt_req(halt_req),
      .sub_halted(sub_halted),
      .halt_n(halt_n),
      .halt_ack_n(halt_ack_n),
      .halt_to(halt_to),
      .halted_entry(halted_entry)
   );
`ifdef SUB_IRQ_MASK_EN
   always_ff @(posedge CLK) begin
      if (!RESETn) mask <= '1;
      else if (irq_mask_wr) mask <= page_wdata[N_IRQ-1:0];
   end
`else
   assign mask = '1;
`endif
   assign sub_irq_n = ~|(irq_pend & mask);
   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         busy <= 1'b0;
         irq_pend <= '0;
         vpage_n <= '0;
         dpage <= '0;
         vd_off_n <= VD_OFF_N_RST;
         ins <= INS_RST;
      end else begin
         busy <= (busy_clr | halted_entry) ? 1'b0 : (busy | busy_set);
         // set is OR-ed after the clear so a coincident event survives
         irq_pend <= (irq_pend & {N_IRQ{~irq_clr}}) | irq_set;
         vd_off_n <= crt_wr ? wbit : vd_off_n;
         ins <= led_wr ? wbit : ins;
         vpage_n <= page_wr ? page_wdata[CPU_PAGE_LSB +: N_PAGES] : vpage_n;
         dpage <= page_wr ? page_wdata[DISP_PAGE_LSB +: N_PAGES] : dpage;
      end
   end
endmodule

// File: tb/tb_sub_flags_ctl.sv
// tb_sub_flags_ctl: self-checking bench for sub_flags_ctl with a behavioural flag model
module tb_sub_flags_ctl;
   logic CLK = 0;
   logic RESETn = 0;
   logic halt_req = 0, sub_halted = 0, busy_set = 0, busy_clr = 0, irq_clr = 0;
   logic [1:0] irq_set = '0;
   logic crt_wr = 0, led_wr = 0, wbit = 0, page_wr = 0;
   logic [7:0] page_wdata = '0;
`ifdef SUB_IRQ_MASK_EN
   logic irq_mask_wr = 0;
`endif
   logic halt_n, halt_ack_n, busy, sub_irq_n, vd_off_n, ins, halt_to;
   logic [1:0] irq_pend;
   logic [2:0] vpage_n, dpage;
   int checks = 0, errors = 0;
   logic m_busy, m_vd, m_ins;
   logic [1:0] m_pend, m_mask;
   int m_vpage, m_dpage;

   always #5 CLK = ~CLK;

   sub_flags_ctl #(.N_IRQ(2), .N_PAGES(3), .ACK_TIMEOUT(8), .TO_W(4)) dut (
      .CLK(CLK), .RESETn(RESETn), .halt_req(halt_req), .sub_halted(sub_halted),
      .busy_set(busy_set), .busy_clr(busy_clr), .irq_set(irq_set), .irq_clr(irq_clr),
`ifdef SUB_IRQ_MASK_EN
      .irq_mask_wr(irq_mask_wr),
`endif
      .crt_wr(crt_wr), .led_wr(led_wr), .wbit(wbit), .page_wr(page_wr), .page_wdata(page_wdata),
      .halt_n(halt_n), .halt_ack_n(halt_ack_n), .busy(busy), .sub_irq_n(sub_irq_n),
      .irq_pend(irq_pend), .vpage_n(vpage_n), .dpage(dpage), .vd_off_n(vd_off_n), .ins(ins),
      .halt_to(halt_to)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
      busy_set = 0; busy_clr = 0; irq_set = '0; irq_clr = 0;
      crt_wr = 0; led_wr = 0; page_wr = 0;
`ifdef SUB_IRQ_MASK_EN
      irq_mask_wr = 0;
`endif
   endtask

   task automatic test_reset();
      RESETn = 0; tick(); RESETn = 1;
      busy_set = 1; irq_set = 2'b11; page_wr = 1; page_wdata = 8'hff;
      crt_wr = 1; led_wr = 1; wbit = 0; halt_req = 1;
      tick(); tick();
      RESETn = 0; tick();
      checks++;
      if ({halt_n, halt_ack_n, busy, irq_pend, sub_irq_n, vpage_n, dpage, vd_off_n, ins, halt_to}
          !== {1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got %b %b %b %b %b %b %b %b %b %b want 1 1 0 00 1 000 000 1 1 0",
                  halt_n, halt_ack_n, busy, irq_pend, sub_irq_n, vpage_n, dpage, vd_off_n, ins, halt_to);
      end
      RESETn = 1; tick();
      checks++;
      if (halt_n !== 1'b0) begin errors++; $display("FAIL post_reset_req: halt_n=%b want 0", halt_n); end
      halt_req = 0; tick();
      checks++;
      if (halt_n !== 1'b1) begin errors++; $display("FAIL post_reset_rel: halt_n=%b want 1", halt_n); end
   endtask

   task automatic test_page();
      page_wr = 1; page_wdata = 8'h75; tick();
      checks++;
      if ({vpage_n, dpage} !== {3'b101, 3'b111}) begin
         errors++; $display("FAIL page_75: vpage_n=%b dpage=%b want 101 111", vpage_n, dpage);
      end
      page_wdata = 8'h00; tick();
      checks++;
      if ({vpage_n, dpage} !== {3'b101, 3'b111}) begin
         errors++; $display("FAIL page_hold: vpage_n=%b dpage=%b want 101 111", vpage_n, dpage);
      end
   endtask

   task automatic test_halt();
      busy_set = 1; tick();
      halt_req = 1; tick();
      checks++;
      if ({halt_n, halt_ack_n, busy} !== 3'b011) begin
         errors++; $display("FAIL halt_req: halt_n,ack_n,busy=%b want 011", {halt_n, halt_ack_n, busy});
      end
      tick(); tick();
      sub_halted = 1; tick();
      checks++;
      if ({halt_n, halt_ack_n, busy} !== 3'b000) begin
         errors++; $display("FAIL halt_ack: halt_n,ack_n,busy=%b want 000", {halt_n, halt_ack_n, busy});
      end
      halt_req = 0; tick();
      checks++;
      if ({halt_n, halt_ack_n} !== 2'b11) begin
         errors++; $display("FAIL halt_rel: halt_n,ack_n=%b want 11", {halt_n, halt_ack_n});
      end
      sub_halted = 0; halt_req = 1; tick();
      halt_req = 0; sub_halted = 1; tick();
      checks++;
      if ({halt_n, halt_ack_n} !== 2'b11) begin
         errors++; $display("FAIL rel_beats_ack: halt_n,ack_n=%b want 11", {halt_n, halt_ack_n});
      end
      sub_halted = 0; tick();
   endtask

   task automatic test_timeout();
      halt_req = 1; tick();
      for (int k = 1; k < 8; k++) begin
         tick();
         checks++;
         if (halt_to !== 1'b0) begin errors++; $display("FAIL to_early: cycle %0d halt_to=%b want 0", k, halt_to); end
      end
      tick();
      checks++;
      if ({halt_to, halt_n} !== 2'b10) begin
         errors++; $display("FAIL to_fire: halt_to,halt_n=%b want 10", {halt_to, halt_n});
      end
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if ({halt_to, halt_n} !== 2'b10) begin
         errors++; $display("FAIL to_sticky: halt_to,halt_n=%b want 10", {halt_to, halt_n});
      end
      halt_req = 0; tick();
      checks++;
      if ({halt_to, halt_n} !== 2'b11) begin
         errors++; $display("FAIL to_release: halt_to,halt_n=%b want 11", {halt_to, halt_n});
      end
      halt_req = 1; tick();
      checks++;
      if ({halt_to, halt_n} !== 2'b00) begin
         errors++; $display("FAIL to_rearm: halt_to,halt_n=%b want 00", {halt_to, halt_n});
      end
      halt_req = 0; tick();
   endtask

   task automatic test_irq();
      irq_set = 2'b01; irq_clr = 1; tick();
      checks++;
      if ({irq_pend, sub_irq_n} !== 3'b010) begin
         errors++; $display("FAIL irq_set_wins: pend,irq_n=%b want 010", {irq_pend, sub_irq_n});
      end
      irq_set = 2'b10; tick();
      checks++;
      if ({irq_pend, sub_irq_n} !== 3'b110) begin
         errors++; $display("FAIL irq_accum: pend,irq_n=%b want 110", {irq_pend, sub_irq_n});
      end
      irq_clr = 1; tick();
      checks++;
      if ({irq_pend, sub_irq_n} !== 3'b001) begin
         errors++; $display("FAIL irq_clr: pend,irq_n=%b want 001", {irq_pend, sub_irq_n});
      end
   endtask

   task automatic test_busy();
      busy_set = 1; tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_set: busy=%b want 1", busy); end
      busy_set = 1; busy_clr = 1; tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_clr_wins: busy=%b want 0", busy); end
      busy_set = 1; tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_reset: busy=%b want 1", busy); end
      busy_clr = 1; tick();
   endtask

   task automatic test_flags();
      crt_wr = 1; wbit = 0; tick();
      led_wr = 1; wbit = 0; tick();
      checks++;
      if ({vd_off_n, ins} !== 2'b00) begin errors++; $display("FAIL flags_load: vd_off_n,ins=%b want 00", {vd_off_n, ins}); end
      wbit = 1; tick();
      checks++;
      if ({vd_off_n, ins} !== 2'b00) begin errors++; $display("FAIL flags_hold: vd_off_n,ins=%b want 00", {vd_off_n, ins}); end
   endtask

`ifdef SUB_IRQ_MASK_EN
   task automatic test_mask();
      irq_clr = 1; tick();
      irq_mask_wr = 1; page_wdata = 8'h02; tick();
      irq_set = 2'b01; tick();
      checks++;
      if ({irq_pend, sub_irq_n} !== 3'b011) begin
         errors++; $display("FAIL mask_block: pend,irq_n=%b want 011", {irq_pend, sub_irq_n});
      end
      irq_mask_wr = 1; page_wdata = 8'h03; tick();
      checks++;
      if ({irq_pend, sub_irq_n} !== 3'b010) begin
         errors++; $display("FAIL mask_open: pend,irq_n=%b want 010", {irq_pend, sub_irq_n});
      end
   endtask
`endif

   task automatic test_random();
      logic [14:0] got, want;
      RESETn = 0; halt_req = 0; sub_halted = 0; tick(); RESETn = 1;
      m_busy = 0; m_pend = 0; m_mask = 2'b11; m_vd = 1; m_ins = 1; m_vpage = 0; m_dpage = 0;
      for (int i = 0; i < 300; i++) begin
         busy_set = $urandom_range(0, 3) == 0;
         busy_clr = $urandom_range(0, 3) == 0;
         irq_set = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
         irq_clr = $urandom_range(0, 4) == 0;
         crt_wr = $urandom_range(0, 3) == 0;
         led_wr = $urandom_range(0, 3) == 0;
         wbit = 1'($urandom_range(0, 1));
         page_wr = $urandom_range(0, 3) == 0;
         page_wdata = 8'($urandom_range(0, 255));
         sub_halted = 1'($urandom_range(0, 1));
`ifdef SUB_IRQ_MASK_EN
         irq_mask_wr = $urandom_range(0, 5) == 0;
         if (irq_mask_wr) m_mask = 2'(page_wdata % 4);
`endif
         if (busy_clr) m_busy = 0; else if (busy_set) m_busy = 1;
         if (irq_clr) m_pend = 0;
         m_pend = m_pend | irq_set;
         if (crt_wr) m_vd = wbit;
         if (led_wr) m_ins = wbit;
         if (page_wr) begin m_vpage = page_wdata % 8; m_dpage = (page_wdata / 16) % 8; end
         tick();
         want = {1'b1, 1'b1, m_busy, m_pend, (m_pend & m_mask) == 0, 3'(m_vpage), 3'(m_dpage), m_vd, m_ins, 1'b0};
         got = {halt_n, halt_ack_n, busy, irq_pend, sub_irq_n, vpage_n, dpage, vd_off_n, ins, halt_to};
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL random_step %0d: got %b want %b", i, got, want);
         end
      end
      sub_halted = 0;
   endtask

   initial begin
      test_reset();
      test_page();
      test_halt();
      test_timeout();
      test_irq();
      test_busy();
      test_flags();
`ifdef SUB_IRQ_MASK_EN
      test_mask();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
